key_debouncer: RTL and testbench
================================

Name: key_debouncer

Overview:
- Conditions raw, active-low, bouncing push-button inputs (board KEY[3:0]) into clean, clock-synchronous signals.
- Sits directly upstream of the lab counters (Counter4/Counter8). It replaces wiring a raw KEY straight into a counter's clock with a single-cycle enable pulse in the system clock domain.
- Outputs per key: a debounced pressed level, a one-cycle press pulse and a one-cycle release pulse.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new key level (10 ms at 50 MHz); minimum 2.
- REPEAT_DELAY, 25000000, cycles held before the first auto-repeat pulse; used only with KEY_AUTOREPEAT_EN.
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses; used only with KEY_AUTOREPEAT_EN.

Ports:
- Clock, input, 1, system clock (CLOCK_50); all state is on the rising edge.
- Resetn, input, 1, asynchronous active-low reset.
- key_n, input, N_KEYS, raw keys, 0 = pressed, asynchronous to Clock.
- pressed, output, N_KEYS, debounced level, 1 = held.
- press_pulse, output, N_KEYS, one-cycle pulse on an accepted press (and on auto-repeat, if enabled).
- release_pulse, output, N_KEYS, one-cycle pulse on an accepted release.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Both synchronizer flops per key and the stable register reset to 1 (released).
  - All counters reset to 0.
  - pressed, press_pulse and release_pulse all reset to 0.
- Synchronizer: two flops per key. The synced value lags key_n by 2 cycles.
- Debounce, per key, independently:
  - Each key has a counter of width clog2(DEBOUNCE_CYCLES+1).
  - Any cycle where synced == stable clears the counter to 0.
  - Each cycle where synced != stable increments the counter.
  - When the counter equals DEBOUNCE_CYCLES-1 and synced still differs, then at that edge: stable <= synced and the counter clears.
- A clean key_n edge is therefore reflected on pressed exactly 2 + DEBOUNCE_CYCLES cycles later.
- Outputs are all registered and update on the same edge as stable:
  - pressed = ~stable.
  - press_pulse[i] is 1 for exactly the one cycle after stable goes 1->0.
  - release_pulse[i] is 1 for exactly the one cycle after stable goes 0->1.
  - press_pulse and release_pulse are never high together for the same key.
- Glitch rejection: a differing run shorter than DEBOUNCE_CYCLES produces no output change, and the counter restarts from 0 on the next differing cycle.
- Simultaneous events: keys never interact. Identical stimulus on several keys yields pulses in the same cycle.
- Key held through reset release: synced becomes 0 while stable is 1, so the press is accepted after debounce and press_pulse fires once.
- Reset mid-count: the partial count is discarded with no output pulse. After reset the key is treated as released.
- Counter never wraps: it is bounded by DEBOUNCE_CYCLES-1 because it clears on acceptance.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - Each key gets a repeat counter, cleared whenever pressed = 0 or on an accepted press.
  - While pressed = 1, it counts up. When it reaches REPEAT_DELAY, press_pulse fires for one cycle.
  - After that, press_pulse fires every REPEAT_PERIOD cycles until release.
  - On release, the repeat counter clears and the normal release_pulse fires.
  - Repeat pulses never coincide with release_pulse.
- Undefined:
  - Exactly one press_pulse per accepted press.
  - No repeat counters are synthesized, and REPEAT_* parameters are ignored.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8; scenario 6 also uses REPEAT_DELAY=20 and REPEAT_PERIOD=6.
1. Reset: Resetn=0 with key_n=4'hF, release at t0 -> pressed=0, no pulses for 50 cycles.
2. Clean press: key_n[0] goes 1->0 at cycle 0 and is held -> pressed[0]=1 and press_pulse[0]=1 at cycle 10 only; key_n[0] back to 1 at cycle 40 -> release_pulse[0]=1 at cycle 50 only, pressed[0]=0 from cycle 50.
3. Bounce rejection: key_n[1] low for 7 cycles, high for 1, low for 7, then high -> no output change on any key.
4. Bounce then settle: key_n[2] toggles every 3 cycles for 30 cycles, then stays 0 -> exactly one press_pulse[2], 10 cycles after the last toggle.
5. Simultaneous keys and reset mid-count:
   - key_n=4'h0 at once -> all four press_pulse bits high in the same cycle.
   - Separately, Resetn pulsed low 5 cycles into a count -> no pulse; the press is re-accepted 10 cycles after reset release if still held.
6. KEY_AUTOREPEAT_EN: key_n[3] held -> press pulses at cycles 10, 30, 36, 42 …; on release, the release_pulse and no further presses.

Source files
------------

// File: rtl/key_debouncer.sv
// Per-key synchronizer and debouncer for active-low push buttons, with registered level, press and release pulses.
// Optional auto-repeat of press_pulse while a key is held is enabled by defining KEY_AUTOREPEAT_EN.
module key_debouncer #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_debouncer: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
  end

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] stable;
  logic [N_KEYS-1:0] accept;
  logic [N_KEYS-1:0] rpt_pulse;

  // Synchronizer and stable level reset to released so a held key is seen as a fresh press.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic [CW-1:0] cnt;

    assign accept[i] = (sync2[i] != stable[i]) && (cnt == CNT_LAST);

    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        cnt <= '0;
      end else if ((sync2[i] == stable[i]) || accept[i]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_rpt
    logic [RW-1:0] rcnt;
    logic          repeating;

    // A release accepted on this edge wins over a repeat hit.
    assign rpt_pulse[i] = pressed[i] && !accept[i] &&
                          (rcnt == (repeating ? PERIOD_LAST : DELAY_LAST));

    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        rcnt      <= '0;
        repeating <= 1'b0;
      end else if (!pressed[i] || accept[i]) begin
        rcnt      <= '0;
        repeating <= 1'b0;
      end else if (rpt_pulse[i]) begin
        rcnt      <= '0;
        repeating <= 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end
`else
  assign rpt_pulse = '0;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      stable        <= '1;
      pressed       <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      stable        <= stable ^ accept;
      pressed       <= ~(stable ^ accept);
      press_pulse   <= (accept & stable) | rpt_pulse;
      release_pulse <= accept & ~stable;
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed scenarios plus random key traffic against a window-rule model.
module tb_key_debouncer;
  localparam int NK = 4;
  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 6;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] pressed, press_pulse, release_pulse;

  key_debouncer #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .key_n(key_n),
    .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse)
  );

  always #5 Clock = ~Clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: key_n as sampled at each edge (bit 0 newest); a new level is accepted when the
  // D synchronized samples ending two edges back all differ from the current stable level.
  logic [D+1:0]  hist [NK];
  logic [NK-1:0] m_stable, e_pressed, e_pp, e_rp;
  int age [NK];
  int pp_count [NK];
  int rp_count [NK];
  int last_pp [NK];
  int last_rp [NK];

  task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      hist[k] = '1;
      age[k]  = 0;
    end
    m_stable  = '1;
    e_pressed = '0;
    e_pp      = '0;
    e_rp      = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    cyc++;
    if (Resetn) begin
      e_pp = '0;
      e_rp = '0;
      for (int k = 0; k < NK; k++) begin
        hist[k] = {hist[k][D:0], key_n[k]};
        if (hist[k][D+1:2] == {D{~m_stable[k]}}) begin
          m_stable[k] = ~m_stable[k];
          if (!m_stable[k]) begin
            e_pp[k] = 1'b1;
            age[k]  = 0;
          end else begin
            e_rp[k] = 1'b1;
          end
        end else if (!m_stable[k]) begin
          age[k]++;
`ifdef KEY_AUTOREPEAT_EN
          if (age[k] == RD || (age[k] > RD && ((age[k] - RD) % RP) == 0)) e_pp[k] = 1'b1;
`endif
        end
      end
      e_pressed = ~m_stable;
    end
    #1;
    chk("pressed", pressed, e_pressed);
    chk("press_pulse", press_pulse, e_pp);
    chk("release_pulse", release_pulse, e_rp);
    chk("pulse_overlap", press_pulse & release_pulse, '0);
    for (int k = 0; k < NK; k++) begin
      if (press_pulse[k]) begin pp_count[k]++; last_pp[k] = cyc; end
      if (release_pulse[k]) begin rp_count[k]++; last_rp[k] = cyc; end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n);
    Resetn = 1'b0;
    model_reset();
    #1;
    chk("reset_outputs", pressed | press_pulse | release_pulse, '0);
    ticks(n);
    Resetn = 1'b1;
  endtask

  initial begin
    int c0;
    int base;
    for (int k = 0; k < NK; k++) begin
      pp_count[k] = 0; rp_count[k] = 0; last_pp[k] = -1; last_rp[k] = -1;
    end
    model_reset();
    #1;

    // 1: reset with keys released, then 50 quiet cycles
    key_n = 4'hF;
    do_reset(3);
    ticks(50);
    chk_int("idle_press_count", pp_count[0] + pp_count[1] + pp_count[2] + pp_count[3], 0);
    chk_int("idle_release_count", rp_count[0] + rp_count[1] + rp_count[2] + rp_count[3], 0);

    // 2: clean press at cycle 0, release at cycle 40
    c0 = cyc;
    key_n[0] = 1'b0;
    ticks(40);
    chk_int("press_latency", last_pp[0] - c0, 10);
    chk_int("press_once", pp_count[0], 1);
    key_n[0] = 1'b1;
    ticks(20);
    chk_int("release_latency", last_rp[0] - c0, 50);
    chk_int("release_once", rp_count[0], 1);

    // 3: bounce runs one cycle too short
    key_n[1] = 1'b0; ticks(7);
    key_n[1] = 1'b1; ticks(1);
    key_n[1] = 1'b0; ticks(7);
    key_n[1] = 1'b1; ticks(30);
    chk_int("bounce_rejected", pp_count[1] + rp_count[1], 0);

    // 4: toggle every 3 cycles, then settle low
    base = pp_count[2];
    for (int t = 0; t < 10; t++) begin
      key_n[2] = ~key_n[2];
      ticks(3);
    end
    c0 = cyc;
    key_n[2] = 1'b0;
    ticks(20);
    chk_int("settle_one_press", pp_count[2] - base, 1);
    chk_int("settle_latency", last_pp[2] - c0, 10);
    key_n[2] = 1'b1;
    ticks(15);

    // 5a: all keys at once
    c0 = cyc;
    key_n = 4'h0;
    ticks(15);
    for (int k = 0; k < NK; k++) chk_int("simul_press", last_pp[k] - c0, 10);
    key_n = 4'hF;
    ticks(15);
    for (int k = 0; k < NK; k++) chk_int("simul_release", last_rp[k] - c0, 25);

    // 5b: reset 5 cycles into a count, key still held
    base = pp_count[0];
    key_n[0] = 1'b0;
    ticks(5);
    do_reset(2);
    c0 = cyc;
    ticks(15);
    chk_int("reaccept_once", pp_count[0] - base, 1);
    chk_int("reaccept_latency", last_pp[0] - c0, 10);
    key_n[0] = 1'b1;
    ticks(15);

`ifdef KEY_AUTOREPEAT_EN
    // 6: held key auto-repeats at 10, 30, 36, 42, 48
    base = pp_count[3];
    key_n[3] = 1'b0;
    ticks(50);
    chk_int("repeat_count", pp_count[3] - base, 5);
    chk_int("repeat_last", last_pp[3] - (cyc - 50), 48);
    base = pp_count[3];
    key_n[3] = 1'b1;
    ticks(30);
    chk_int("repeat_stops", pp_count[3] - base, 0);
`endif

    // random traffic with occasional mid-stream resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 40) == 0) begin
        do_reset($urandom_range(1, 3));
      end
      key_n = NK'($urandom);
      ticks($urandom_range(1, 14));
    end
    key_n = '1;
    ticks(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
